// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory port arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int DATA_W = 32;
endpackage

// File: rtl/arb_prio_pick.sv
// arb_prio_pick: data-over-fetch winner select, overridden when fetch is starved
// Ports: i_req/d_req requests, starved = starve counter at limit, win_d = data wins
module arb_prio_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic starved,
  output logic win_d
);
  always_comb win_d = d_req && !(i_req && starved);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between CPU fetch and load/store ports
// Ports: clk/rst; fetch i_req/i_addr -> i_gnt/i_rvalid/i_rdata;
// data d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata;
// RAM mem_en/mem_we/mem_addr/mem_wdata, mem_rdata valid the cycle after mem_en.
// Optional MEM_PORT_ARB_STATS_EN adds stat_i_grants/stat_d_grants/stat_conflicts.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARB_STATS_EN
  ,
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
`endif
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  arb_state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic idle, starved, win_d;
  assign starved = starve_q == LIMIT;
  arb_prio_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .starved(starved),
    .win_d  (win_d)
  );
  // Outputs are gated by rst so nothing is granted or signalled in a reset cycle.
  always_comb begin
    idle      = state_q == IDLE && !rst;
    d_gnt     = idle && win_d;
    i_gnt     = idle && i_req && !win_d;
    mem_en    = i_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = d_gnt ? d_addr : i_gnt ? i_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    i_rvalid  = state_q == RESP && owner_q == OWN_I && !rst;
    d_rvalid  = state_q == RESP && owner_q == OWN_D && !rst;
    i_rdata   = i_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
    state_d   = mem_en ? RESP : IDLE;
    owner_d   = d_gnt ? OWN_D : i_gnt ? OWN_I : owner_q;
    // Counts data grants that beat a waiting fetch; any idle cycle without fetch
    // pending, or a fetch grant, restarts the count.
    starve_d  = state_q != IDLE ? starve_q :
                (!i_req || i_gnt) ? 4'd0 :
                (d_gnt && !starved) ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end
`ifdef MEM_PORT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_i_grants  <= stat_i_grants + 32'(i_gnt);
      stat_d_grants  <= stat_d_grants + 32'(d_gnt);
      stat_conflicts <= stat_conflicts + 32'(idle && i_req && d_req);
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven bench for mem_port_arbiter with a sync RAM model
module tb_mem_port_arbiter;
  logic clk, rst;
  logic i_req, i_gnt, i_rvalid;
  logic [11:0] i_addr;
  logic [31:0] i_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [11:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef MEM_PORT_ARB_STATS_EN
  logic [31:0] stat_i_grants, stat_d_grants, stat_conflicts;
`endif
  int n_cmp = 0;
  int n_err = 0;
  logic proto_en = 1'b1;
  logic pi = 1'b0, pig = 1'b0, pd = 1'b0, pdg = 1'b0;
  logic [31:0] ram [0:4095];

  mem_port_arbiter #(.AW(12), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARB_STATS_EN
    , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Sync RAM model: read data appears the cycle after mem_en; reads as 0 on a write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= mem_we ? 32'h0 : ram[mem_addr];
    end
  end

  // A requester must hold req until it sees gnt.
  always @(posedge clk) begin
    assert (!(proto_en && !rst && pi && !pig) || i_req) else $error("protocol: i_req dropped before i_gnt");
    assert (!(proto_en && !rst && pd && !pdg) || d_req) else $error("protocol: d_req dropped before d_gnt");
    pi  <= i_req && !rst;
    pig <= i_gnt;
    pd  <= d_req && !rst;
    pdg <= d_gnt;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [113:0] obs();
    return {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, i_rdata, d_rdata, mem_addr, mem_wdata};
  endfunction

  // One IDLE grant cycle followed by its RESP cycle, requests held throughout.
  task automatic grant(input logic ir, input logic dr, input logic exp_i, input string nm);
    i_req = ir; d_req = dr; d_we = 0; i_addr = 12'h010; d_addr = 12'h020;
    #1 chk(nm, {i_gnt, d_gnt}, {exp_i, !exp_i});
    @(negedge clk);
    #1 chk({nm, "_resp"}, {i_gnt, d_gnt, mem_en, i_rvalid, d_rvalid, i_rdata, d_rdata},
           {3'b000, exp_i, !exp_i, exp_i ? 32'hDEADBEEF : 32'h0, exp_i ? 32'h0 : 32'h12345678});
    @(negedge clk);
  endtask

  typedef struct {
    logic ir; logic [11:0] ia; logic dr; logic dw; logic [11:0] da; logic [31:0] dd;
    logic [113:0] exp;
  } vec_t;
  vec_t v [9];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    ram[12'h010] = 32'hDEADBEEF;
    mem_rdata = 32'h0;
    v[0] = '{1, 12'h010, 0, 0, 12'h000, 32'h0,      {6'b100010, 32'h0, 32'h0, 12'h010, 32'h0}};
    v[1] = '{0, 12'h000, 0, 0, 12'h000, 32'h0,      {6'b001000, 32'hDEADBEEF, 32'h0, 12'h000, 32'h0}};
    v[2] = '{0, 12'h000, 1, 1, 12'h020, 32'h12345678, {6'b010011, 32'h0, 32'h0, 12'h020, 32'h12345678}};
    v[3] = '{0, 12'h000, 0, 0, 12'h000, 32'h0,      {6'b000100, 32'h0, 32'h0, 12'h000, 32'h0}};
    v[4] = '{0, 12'h000, 1, 0, 12'h020, 32'hAAAA5555, {6'b010010, 32'h0, 32'h0, 12'h020, 32'hAAAA5555}};
    v[5] = '{1, 12'h010, 0, 0, 12'h000, 32'h0,      {6'b000100, 32'h0, 32'h12345678, 12'h000, 32'h0}};
    v[6] = '{1, 12'h010, 0, 0, 12'h000, 32'h0,      {6'b100010, 32'h0, 32'h0, 12'h010, 32'h0}};
    v[7] = '{0, 12'h000, 0, 0, 12'h000, 32'h0,      {6'b001000, 32'hDEADBEEF, 32'h0, 12'h000, 32'h0}};
    v[8] = '{0, 12'h123, 0, 1, 12'h456, 32'hCAFEF00D, {6'b000000, 32'h0, 32'h0, 12'h000, 32'h0}};

    rst = 1; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    @(negedge clk);
    i_req = 1; d_req = 1; d_we = 1; i_addr = 12'h010; d_addr = 12'h020;
    #1 chk("reset_outputs", obs(), 114'h0);
    @(negedge clk);
    rst = 0;

    for (int k = 0; k < 9; k++) begin
      i_req = v[k].ir; i_addr = v[k].ia; d_req = v[k].dr; d_we = v[k].dw;
      d_addr = v[k].da; d_wdata = v[k].dd;
      #1 chk($sformatf("vec%0d", k), obs(), v[k].exp);
      @(negedge clk);
    end

    for (int g = 0; g < 10; g++) grant(1, 1, g % 5 == 4, $sformatf("arb%0d", g));

    proto_en = 0;
    grant(1, 1, 0, "stv0");
    grant(1, 1, 0, "stv1");
    grant(0, 1, 0, "stv2");
    for (int g = 0; g < 4; g++) grant(1, 1, 0, $sformatf("stv_d%0d", g));
    grant(1, 1, 1, "stv_i");

    i_req = 0; d_req = 1; d_we = 0; d_addr = 12'h020;
    #1 chk("rr_dgnt", {d_gnt, mem_en, mem_addr}, {2'b11, 12'h020});
    @(negedge clk);
    rst = 1; d_req = 0; i_req = 1; i_addr = 12'h010;
    #1 chk("rr_suppress", {d_rvalid, i_rvalid, i_gnt, mem_en, d_rdata}, 36'h0);
    @(negedge clk);
    rst = 0;
    #1 chk("rr_igrant", {i_gnt, d_gnt, mem_en, mem_addr}, {3'b101, 12'h010});
    @(negedge clk);
    proto_en = 1; i_req = 0;
    #1 chk("rr_irvalid", {i_rvalid, i_rdata}, {1'b1, 32'hDEADBEEF});
    @(negedge clk);

`ifdef MEM_PORT_ARB_STATS_EN
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 chk("stat_clear0", {stat_i_grants, stat_d_grants, stat_conflicts}, 96'h0);
    @(negedge clk);
    for (int g = 0; g < 10; g++) grant(1, 1, g % 5 == 4, $sformatf("st%0d", g));
    proto_en = 0; i_req = 0; d_req = 0;
    #1 chk("stat_i", stat_i_grants, 32'd2);
    chk("stat_d", stat_d_grants, 32'd8);
    chk("stat_conf_ge10", stat_conflicts >= 32'd10, 1'b1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 chk("stat_clear1", {stat_i_grants, stat_d_grants, stat_conflicts}, 96'h0);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the CPU instruction-fetch port and the load/store data port, so code and data can live in a unified memory.
- Sits between the multicycle CPU and the RAM block.
- Arbitrates with fixed data-over-fetch priority plus a starvation guard.
- Sequences each access through a two-state issue/response FSM with a per-port req/gnt/rvalid handshake.

Parameters:
- AW, 12, word-address width driven to the RAM.
- STARVE_LIMIT, 4, consecutive data grants, while fetch is also requesting, after which fetch wins (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_gnt.
- i_addr  in  AW  fetch word address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  32  fetch read data.
- d_req  in  1  data request; held high until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data word address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  32  load data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid the cycle after mem_en.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- FSM states: IDLE, RESP.
  - IDLE: if any request is present, pick a winner. Assert its gnt and mem_en combinationally in the same cycle. Drive mem_addr from the winner's address; for a data winner also drive mem_we = d_we and mem_wdata = d_wdata. Next state is RESP, and the winner is latched in owner.
  - RESP: assert owner's rvalid for exactly 1 cycle. rdata = mem_rdata, passed through. No gnt and no mem_en in this state. Next state is IDLE.
- Throughput and latency:
  - One access every 2 cycles.
  - Latency from gnt to rvalid is exactly 1 cycle.
  - A new request seen in RESP is granted no earlier than the following IDLE cycle.
- Arbitration:
  - Only d_req: data wins.
  - Only i_req: fetch wins.
  - Both requesting: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt (4 bit):
  - Increments on a data grant while i_req is high.
  - Clears on a fetch grant, or whenever i_req is low in IDLE.
  - Saturates at STARVE_LIMIT.
- Stores: d_rvalid still pulses in RESP as the write acknowledge; d_rdata is don't-care on that pulse.
- Non-owner outputs:
  - rvalid = 0.
  - rdata = 0 when not valid, so the bench can check it.
- Idle outputs: when mem_en = 0, mem_we = 0 and mem_addr/mem_wdata = 0.
- Reset:
  - Puts state in IDLE, owner = fetch, starve_cnt = 0.
  - All gnt/rvalid/mem_en/mem_we outputs are 0 during the reset cycle.
  - Reset asserted in RESP suppresses that rvalid pulse. A write already issued is not undone.
- Request protocol:
  - A requester must not drop req before gnt; if it does, behaviour is undefined (assertion in bench).
  - Address and data are sampled only in the gnt cycle.
- Widths: no arithmetic on addresses; addresses pass through unchanged.

Optional Feature:
- Macro: MEM_PORT_ARB_STATS_EN.
- When defined, three extra output ports are added:
  - stat_i_grants (32 bit): counts fetch grants.
  - stat_d_grants (32 bit): counts data grants.
  - stat_conflicts (32 bit): counts IDLE cycles with i_req && d_req.
- All three counters wrap modulo 2^32 and clear on rst.
- When undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, RESP};
  - typedef enum owner_t {OWN_I, OWN_D};
  - localparam DATA_W = 32.
- One natural sub-module, arb_prio_pick:
  - Combinational winner select from i_req, d_req and starved (= starve_cnt == STARVE_LIMIT).
  - Output win_d.
- FSM, starve counter and stats stay in the top module.

Test Plan:
- Fetch only: preload RAM[0x010] = 0xDEADBEEF; hold i_req with i_addr = 0x010 → i_gnt in cycle 0, i_rvalid with i_rdata = 0xDEADBEEF in cycle 1, d_* outputs stay 0.
- Store then load: d_req, d_we = 1, d_addr = 0x020, d_wdata = 0x12345678 → d_gnt, then d_rvalid ack. Next, d_req with d_we = 0 at 0x020 → d_rdata = 0x12345678 exactly 1 cycle after d_gnt.
- Simultaneous requests: i_req and d_req both held continuously with STARVE_LIMIT = 4 → grant order D,D,D,D,I,D,D,D,D,I…; i_gnt never more than 5 grants apart.
- Starve clear: i_req drops after 2 data grants, then rises again → starve_cnt restarts from 0, so 4 further data grants precede the next fetch grant.
- Reset in RESP: assert rst in the cycle after d_gnt for a load → d_rvalid stays 0. After rst releases, the state is IDLE and a new i_req is granted on the first IDLE cycle.
- MEM_PORT_ARB_STATS_EN defined: run 10 simultaneous request pairs → stat_i_grants = 2, stat_d_grants = 8, stat_conflicts ≥ 10; all three read 0 after rst.
